// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: consumer request, Gray pointers crossing
// domains, and the status the read controller reports back.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              i_ren;
    logic [ADDR_W:0]   g_w_ptr;
    logic              i_clr_uflow;
    logic [ADDR_W:0]   g_r_ptr_next;
    logic              empty_flag;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              uflow;

    modport master (
        output i_ren, g_w_ptr, i_clr_uflow,
        input  g_r_ptr_next, empty_flag, almost_empty, rd_level, uflow
    );

    modport slave (
        input  i_ren, g_w_ptr, i_clr_uflow,
        output g_r_ptr_next, empty_flag, almost_empty, rd_level, uflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: write-pointer synchronizer,
// binary/Gray read pointer, empty / almost-empty / level and sticky underflow.
module fifo_rd_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic          i_rclk,
    input  logic          i_rrst,
    fifo_rd_ctrl_if.slave rd_if
);
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AE_LIMIT = (ADDR_W + 1)'(AE_THRESH);

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b = g;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0] rbin_q, rbin_d;
    logic [ADDR_W:0] rgray_q, rgray_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            empty_q, empty_d;
    logic            ae_q, ae_d;
    logic            uflow_q, uflow_d;
    logic            rd_fire;
    logic [ADDR_W:0] wq_bin;

    // Next-state: pointer advance, flags derived from the next read pointer
    always_comb begin
        rd_fire = rd_if.i_ren & ~empty_q;
        wq_bin  = gray2bin(sync_q[SYNC_STAGES-1]);
        if (rd_fire) begin
            rbin_d = rbin_q + PTR_ONE;
        end else begin
            rbin_d = rbin_q;
        end
        rgray_d = bin2gray(rbin_d);
        // Level uses a stale write pointer, so it can only under-report
        level_d = wq_bin - rbin_d;
        empty_d = (rgray_d == sync_q[SYNC_STAGES-1]);
        ae_d    = (level_d <= AE_LIMIT);
        if (rd_if.i_ren & empty_q) begin
            uflow_d = 1'b1;
        end else if (rd_if.i_clr_uflow) begin
            uflow_d = 1'b0;
        end else begin
            uflow_d = uflow_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            sync_q  <= '0;
            rbin_q  <= '0;
            rgray_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            uflow_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rd_if.g_w_ptr};
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            level_q <= level_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            uflow_q <= uflow_d;
        end
    end

    assign rd_if.g_r_ptr_next = rgray_q;
    assign rd_if.empty_flag   = empty_q;
    assign rd_if.almost_empty = ae_q;
    assign rd_if.rd_level     = level_q;
    assign rd_if.uflow        = uflow_q;
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain control for the asynchronous FIFO.
- Brings the write-domain Gray write pointer into the read clock through a synchronizer chain.
- Maintains the read pointer in binary and Gray form and drives the Gray read pointer and empty flag to the FIFO storage.
- Also produces a fill-level estimate, an almost-empty flag and a sticky underflow flag. The write-domain controller consumes its Gray read pointer.

Parameters:
- ADDR_W, 3, storage address width; depth = 2**ADDR_W, pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flip-flop stages in the write-pointer synchronizer (legal 2..4).
- AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH.

Ports:
- i_rclk  input  1  read clock; all state updates on rising edge.
- i_rrst  input  1  synchronous active-high reset.
- i_ren  input  1  read request from consumer.
- g_w_ptr  input  ADDR_W+1  Gray write pointer from write domain (asynchronous to i_rclk).
- i_clr_uflow  input  1  clears sticky underflow.
- g_r_ptr_next  output  ADDR_W+1  registered Gray read pointer; to storage and write domain.
- empty_flag  output  1  registered empty indication to storage and consumer.
- almost_empty  output  1  registered, level <= AE_THRESH.
- rd_level  output  ADDR_W+1  registered entries available (0..2**ADDR_W).
- uflow  output  1  sticky underflow flag.

Behaviour:
- One clock i_rclk; reset synchronous, active-high on i_rrst.
- Reset values (effective at the first rising edge with i_rrst=1):
  - binary read pointer rbin = 0, g_r_ptr_next = 0.
  - All synchronizer stages = 0.
  - empty_flag = 1, almost_empty = 1, rd_level = 0, uflow = 0.
- Reset mid-operation drops all state, including a read that is in progress; the next read after release addresses entry 0.
- Qualified read: rd_fire = i_ren & !empty_flag, using the registered empty_flag.
- On rd_fire:
  - rbin_next = rbin + 1, mod 2**(ADDR_W+1).
  - Otherwise rbin_next = rbin.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rbin <= rbin_next; g_r_ptr_next <= rgray_next.
- Storage address = low ADDR_W bits of the binary form of g_r_ptr_next. Storage returns data one edge after rd_fire (read latency 1).
- Synchronizer:
  - g_w_ptr is sampled into stage 1; each later stage copies the previous one.
  - wq = last stage. No logic between stages.
- empty_flag <= (rgray_next == wq), so it is computed from the next read pointer. A read of the last entry sets empty_flag on the same edge that advances the pointer. No extra read may slip through.
- Level:
  - wbin = Gray-to-binary of wq.
  - rd_level <= (wbin - rbin_next) mod 2**(ADDR_W+1).
  - almost_empty <= (that value <= AE_THRESH).
  - Conservative: may under-report by up to SYNC_STAGES writes, never over-reports.
- Latency: g_w_ptr changes before edge E0; with SYNC_STAGES=2, wq updates at E1 and empty_flag/rd_level update at E2. A read-side change is therefore seen SYNC_STAGES+1 edges after g_w_ptr moves.
- Wrap-around:
  - Pointer MSB toggles every 2**ADDR_W reads.
  - The Gray sequence must stay single-bit-change across the 15->0 wrap (ADDR_W=3).
  - Empty compares all ADDR_W+1 bits, so full-lap equality means empty only when the MSBs also match.
- Underflow: i_ren=1 while empty_flag=1 leaves the pointer unchanged and sets uflow <= 1.
- uflow clears only on i_rrst or i_clr_uflow. If a set and a clear occur on the same edge, set wins.
- Simultaneous write arrival and last-entry read: empty_flag follows the formula using the wq value at that edge. It deasserts on a later edge once the new wq propagates.

Test Plan:
- Reset: i_rrst=1 for 2 cycles with g_w_ptr=4'b0110 -> after release, g_r_ptr_next=0, empty_flag=1, rd_level=0, uflow=0. Then empty_flag=0, rd_level=4 three edges after release.
- Sync latency: g_w_ptr 0->4'b0001 before edge E0 -> empty_flag stays 1 at E0 and E1, becomes 0 at E2; rd_level=1, almost_empty=1.
- Drain: wq holds 3 entries (gray 4'b0010) and i_ren is held high -> g_r_ptr_next steps 0001, 0011, 0010. empty_flag rises on the third read edge. A fourth i_ren is ignored and sets uflow=1.
- Wrap: 20 writes/reads interleaved in steps of 8 -> g_r_ptr_next passes 1000 (bin 15) -> 0000 (bin 0) with a single-bit change. empty_flag is correct when write and read pointers are equal only modulo 8 (not empty when rd_level=8).
- Underflow clear: set uflow, then assert i_clr_uflow and an underflowing i_ren on the same edge -> uflow stays 1. Clear alone -> uflow=0 next edge.
- Mid-operation reset: assert i_rrst during continuous reads with rd_level=5 -> next edge all outputs at reset values. After release, empty_flag re-evaluates against the synchronized g_w_ptr.
